seq_divider_8: RTL
==================

Name: seq_divider_8

Overview:
- Sequential unsigned restoring divider.
- Counterpart of the add-and-shift-right multiplier datapath: the combined remainder:quotient register shifts left, and a trial subtract replaces the add.
- Takes a WIDTH-bit dividend and divisor from the switch/operand inputs and produces quotient and remainder after WIDTH iteration cycles.
- Uses the same Run-pulse handshake as the multiplier control: one operation per Run press, with no restart while Run is held.

Parameters:
- WIDTH, 8, operand/result width in bits; counter width is clog2(WIDTH)+1.

Ports:
- Clk  in  1  system clock, all state updates on posedge.
- Reset  in  1  synchronous, active-high; overrides all other inputs.
- Run  in  1  start request, level-sampled in IDLE.
- Dividend  in  WIDTH  unsigned dividend, sampled on the start edge only.
- Divisor  in  WIDTH  unsigned divisor, sampled on the start edge only.
- Quotient  out  WIDTH  quotient register.
- Remainder  out  WIDTH  remainder register.
- Done  out  1  high while in DONE state.
- DivByZero  out  1  high with Done when the latched divisor was 0.

Behaviour:
- Reset values: Quotient=0, Remainder=0, Done=0, DivByZero=0, internal divisor D=0, cnt=0, state=IDLE. Reset mid-operation aborts immediately; the next cycle is IDLE with the same reset values.
- FSM states: IDLE, CALC, DONE.
- IDLE with Run=1 and Divisor!=0, at the edge:
  - R<=0, Q<=Dividend, D<=Divisor, cnt<=0, DivByZero<=0.
  - state<=CALC.
- IDLE with Run=1 and Divisor==0, at the edge:
  - Q<=all ones, R<=Dividend, DivByZero<=1.
  - state<=DONE; no CALC cycles.
- IDLE with Run=0: all registers hold, so results of the previous operation remain visible.
- CALC, one iteration per clock:
  - s = {R, Q[WIDTH-1]} (WIDTH+1 bits); t = s - {1'b0, D} (WIDTH+1 bits, borrow = t[WIDTH]).
  - No borrow: R<=t[WIDTH-1:0], Q<={Q[WIDTH-2:0],1'b1}.
  - Borrow: R<=s[WIDTH-1:0], Q<={Q[WIDTH-2:0],1'b0}.
  - cnt<=cnt+1. When cnt==WIDTH-1 at the edge, state<=DONE.
- Latency: start edge E0, then CALC edges E1..E_WIDTH. Done=1 in the cycle after E_WIDTH (8 cycles after the start edge for WIDTH=8).
- DONE:
  - Done=1; Q, R and DivByZero hold.
  - Run=1: stay in DONE. Holding Run never retriggers.
  - Run=0: state<=IDLE, Done<=0.
- Run changes during CALC are ignored. Operand input changes after E0 have no effect.
- Invariant at Done: Dividend == Q*D + R and R < D, for all D != 0.
- All arithmetic is unsigned; there is no signed mode.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, CALC, DONE).
  - DIV_WIDTH=8 default constant.
  - counter-width localparam helper.
- Sub-module rq_shift_reg: 2*WIDTH-bit left-shift register holding {R,Q}.
  - Inputs: Clk, Reset, Load (loads {0,Dividend}), Shift, Q-bit-in, R-load value.
  - Synchronous reset to 0.
  - Instantiated once by seq_divider_8.
- The FSM, counter, D register and subtractor stay in the top module.

Test Plan:
- Dividend=100 (0x64), Divisor=7, Run pulse -> Done rises exactly 8 cycles after the start edge; Quotient=14 (0x0E), Remainder=2, DivByZero=0.
- 255/1 -> Q=255, R=0. 255/255 -> Q=1, R=0. 5/10 -> Q=0, R=5. 0/3 -> Q=0, R=0.
- Divisor=0, Dividend=200 -> Done after 1 edge; Q=0xFF, R=200, DivByZero=1. A following 9/3 clears DivByZero and gives Q=3, R=0.
- Run held high for 30 cycles -> exactly one operation; Done stays 1. Change operands while held -> outputs unchanged. Release Run -> IDLE, Done=0, results held.
- Assert Reset at CALC cycle 4 of 100/7 -> next cycle IDLE, Q=R=0, Done=0. A subsequent 100/7 completes correctly.
- Random sweep of 10k operand pairs (D!=0) -> Q*D+R==Dividend and R<D every time; latency is always 8.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Imported by the top-level divider and its remainder:quotient shift register.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } divState_t;

   localparam int DIV_WIDTH = 8;

   // One extra bit lets the counter reach WIDTH without wrapping.
   function automatic int cntWidth(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/rq_shift_reg.sv
// Combined {remainder, quotient} register of the restoring divider.
// Shifts left once per iteration, replacing the remainder half with the trial result.
module rq_shift_reg
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic             i_loadDbz,
   input  logic             i_shift,
   input  logic             i_qBit,
   input  logic [WIDTH-1:0] i_rNext,
   input  logic [WIDTH-1:0] i_dividend,
   output logic [WIDTH-1:0] o_remainder,
   output logic [WIDTH-1:0] o_quotient
);

   logic [2*WIDTH-1:0] r_rq;

   // A divide-by-zero start parks the dividend in the remainder half and saturates the quotient.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rq <= '0;
      end else if (i_load) begin
         r_rq <= {{WIDTH{1'b0}}, i_dividend};
      end else if (i_loadDbz) begin
         r_rq <= {i_dividend, {WIDTH{1'b1}}};
      end else if (i_shift) begin
         r_rq <= {i_rNext, r_rq[WIDTH-2:0], i_qBit};
      end
   end

   assign o_remainder = r_rq[2*WIDTH-1:WIDTH];
   assign o_quotient  = r_rq[WIDTH-1:0];

endmodule

// File: rtl/seq_divider_8.sv
// Sequential unsigned restoring divider: one quotient bit per clock over WIDTH cycles.
// A Run level in IDLE starts one operation; Run must drop before another can begin.
module seq_divider_8
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_run,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_done,
   output logic             o_divByZero
);

   localparam int CNT_W = cntWidth(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   divState_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_divisor;
   logic             r_done;
   logic             r_divByZero;

   logic             w_start;
   logic             w_load;
   logic             w_loadDbz;
   logic             w_shift;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH:0]   w_partial;
   logic [WIDTH:0]   w_trial;
   logic             w_borrow;
   logic [WIDTH-1:0] w_rNext;

   assign w_start   = (r_state == IDLE) && i_run;
   assign w_load    = w_start && (i_divisor != '0);
   assign w_loadDbz = w_start && (i_divisor == '0);
   assign w_shift   = (r_state == CALC);

   // Trial subtract of the divisor from the remainder extended by the next dividend bit.
   assign w_partial = {w_rem, w_quo[WIDTH-1]};
   assign w_trial   = w_partial - {1'b0, r_divisor};
   assign w_borrow  = w_trial[WIDTH];
   assign w_rNext   = w_borrow ? w_partial[WIDTH-1:0] : w_trial[WIDTH-1:0];

   rq_shift_reg #(
      .WIDTH(WIDTH)
   ) u_rqShiftReg (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_load),
      .i_loadDbz  (w_loadDbz),
      .i_shift    (w_shift),
      .i_qBit     (~w_borrow),
      .i_rNext    (w_rNext),
      .i_dividend (i_dividend),
      .o_remainder(w_rem),
      .o_quotient (w_quo)
   );

   // Control FSM: Done and DivByZero are registered alongside the state so they change on its edges.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_divisor   <= '0;
         r_done      <= 1'b0;
         r_divByZero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_run) begin
                  if (i_divisor != '0) begin
                     r_divisor   <= i_divisor;
                     r_cnt       <= '0;
                     r_divByZero <= 1'b0;
                     r_state     <= CALC;
                  end else begin
                     r_divByZero <= 1'b1;
                     r_done      <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            CALC: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (!i_run) begin
                  r_done  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_quotient  = w_quo;
   assign o_remainder = w_rem;
   assign o_done      = r_done;
   assign o_divByZero = r_divByZero;

endmodule
